cr_kme_drng_guid_fetch: RTL
===========================

# cr_kme_drng_guid_fetch

Consumer-side controller for the KME AES-256 DRNG. It seeds and starts the DRNG whenever the DRNG reports an expired seed, pops two 128-bit random words from the DRNG output FIFO, and assembles them into a 256-bit random GUID. The GUID is presented to the key-processing logic on a valid/ack handshake. The block sits between the KME control path, which requests GUIDs, and the DRNG's `drng_valid`/`drng_ack` output port.

## Interface
- TIMEOUT_CYCLES, 1024: number of wait cycles without a DRNG word before a timeout pulse; legal range 2..65535.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- guid_req  in  1  request one GUID; sampled only in IDLE.
- guid_valid  out  1  GUID available; held until acked.
- guid  out  256  assembled GUID; stable while guid_valid.
- guid_ack  in  1  consumer accepts GUID.
- cfg_seed  in  384  seed value to load into the DRNG.
- cfg_seed_life  in  48  DRNG iterations allowed per seed.
- seed_expired  in  1  from DRNG: seed exhausted, restart required.
- drng_valid  in  1  from DRNG: FIFO head word valid.
- drng_256_out  in  128  from DRNG: FIFO head word.
- drng_start  out  1  to DRNG: one-cycle start pulse.
- drng_seed  out  384  to DRNG: registered seed.
- drng_seed_life  out  48  to DRNG: registered seed life.
- drng_ack  out  1  to DRNG: pop FIFO head.
- guid_timeout  out  1  one-cycle pulse on wait timeout.
- reseed_count  out  16  count of `drng_start` pulses; saturates at 16'hFFFF.

## Operation
- States: IDLE, SEED, WAIT, PRESENT. A `half` flag records the word index: 0 = low word pending, 1 = high word pending.
- IDLE transitions on `guid_req`:
  - If `seed_expired`, go to SEED.
  - Otherwise, go to WAIT with `half`=0.
- SEED:
  - `drng_start`=1 for exactly one cycle.
  - `drng_seed` and `drng_seed_life` load from `cfg_seed` and `cfg_seed_life` on entry to SEED and hold until the next entry.
  - `reseed_count` increments and saturates.
  - Next state is WAIT; `half` is preserved.
- WAIT, evaluated in priority order:
  - If `drng_valid`: `drng_ack`=1 combinationally in the same cycle. If `half`=0, capture `guid[127:0]`, set `half`=1 and stay in WAIT. If `half`=1, capture `guid[255:128]` and go to PRESENT.
  - Else if `seed_expired`: go to SEED.
  - Else: the timeout counter increments.
- `drng_ack` is never asserted outside WAIT and never without `drng_valid`. The block therefore cannot cause a DRNG FIFO underflow.
- PRESENT: `guid_valid`=1 with `guid` held. On `guid_ack`, go to IDLE and clear `half`. `guid_req` is ignored outside IDLE.
- Timeout counter (16 bits):
  - Clears on every word capture and on leaving WAIT.
  - When it reaches TIMEOUT_CYCLES-1 in WAIT with no `drng_valid`, `guid_timeout` pulses for one cycle, the counter returns to 0, and the FSM stays in WAIT.
- A captured word is never discarded, except on reset.

## Timing
- Reset values: `drng_start`, `drng_ack`, `guid_valid` and `guid_timeout` = 0. `guid`, `drng_seed`, `drng_seed_life`, `reseed_count`, `half` and the timeout counter = 0. State = IDLE.
- Reset mid-operation returns to IDLE next cycle and drops any partial GUID. The DRNG FIFO is not touched.
- All outputs are registered except `drng_ack`, which is decoded from state and `drng_valid`.
- Best-case latency, no reseed, `drng_valid` held high: `guid_req` sampled at cycle N, low word captured N+1, high word captured N+2, `guid_valid` high at N+3. A reseed adds one cycle plus the DRNG's fill time.
- `drng_seed` is stable from the SEED cycle onward. It is therefore valid throughout the DRNG's seed-expired sampling window.
- `guid_ack` with `guid_valid` at cycle M gives `guid_valid`=0 at M+1. A new `guid_req` at M+1 is accepted.
- `drng_valid` and `seed_expired` both high in WAIT: the word is consumed and no reseed is started. The reseed is taken only once the FIFO is empty.
- `guid_ack` asserted while `guid_valid`=0: ignored.

## Test plan
- Reset, then `guid_req` with `seed_expired`=1, `cfg_seed`=384'h1…, `cfg_seed_life`=48'd3 -> one `drng_start` pulse, `drng_seed` matches `cfg_seed`, `reseed_count`=1.
- `seed_expired`=0, `drng_valid` held high with words 128'hA then 128'hB -> `guid`={B,A}, `guid_valid` exactly 3 cycles after `guid_req`, exactly 2 `drng_ack` pulses.
- Low word delivered, then `drng_valid`=0 and `seed_expired`=1 -> SEED reentered, `reseed_count`+1; next word lands in `guid[255:128]`, and the low word is retained.
- TIMEOUT_CYCLES=8, `drng_valid` held low in WAIT for 20 cycles -> `guid_timeout` pulses at wait cycles 8 and 16; no `drng_ack`.
- `guid_ack` withheld for 10 cycles while `drng_valid`=1 -> `guid` stable, `drng_ack`=0 throughout; after ack, back-to-back `guid_req` is served.
- `rst` asserted while in WAIT with `half`=1 -> all outputs 0 next cycle; the following request rebuilds the GUID from the low word.

Source files
------------

// File: rtl/cr_kme_drng_guid_fetch.sv
// Consumer-side controller for the KME AES-256 DRNG: reseeds on demand, pops two
// 128-bit words from the DRNG FIFO and presents them as one 256-bit GUID.
module cr_kme_drng_guid_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         guid_req,
  output logic         guid_valid,
  output logic [255:0] guid,
  input  logic         guid_ack,
  input  logic [383:0] cfg_seed,
  input  logic [47:0]  cfg_seed_life,
  input  logic         seed_expired,
  input  logic         drng_valid,
  input  logic [127:0] drng_256_out,
  output logic         drng_start,
  output logic [383:0] drng_seed,
  output logic [47:0]  drng_seed_life,
  output logic         drng_ack,
  output logic         guid_timeout,
  output logic [15:0]  reseed_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEED    = 2'd1,
    WAIT    = 2'd2,
    PRESENT = 2'd3
  } state_e;

  // The timeout pulse is registered, so it is armed one count early: the pulse
  // appears in the cycle the counter sits at TIMEOUT_CYCLES-1, which then wraps.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] TMO_ARM  = 16'(TIMEOUT_CYCLES - 2);

  state_e         state_q, state_d;
  logic           half_q, half_d;
  logic [15:0]    tmo_cnt_q, tmo_cnt_d;
  logic [255:0]   guid_q, guid_d;
  logic [383:0]   seed_q, seed_d;
  logic [47:0]    seed_life_q, seed_life_d;
  logic [15:0]    reseed_cnt_q, reseed_cnt_d;
  logic           start_q, start_d;
  logic           guid_valid_q, guid_valid_d;
  logic           timeout_q, timeout_d;
  logic           enter_seed;

  always_comb begin
    state_d      = state_q;
    half_d       = half_q;
    tmo_cnt_d    = tmo_cnt_q;
    guid_d       = guid_q;
    seed_d       = seed_q;
    seed_life_d  = seed_life_q;
    reseed_cnt_d = reseed_cnt_q;
    start_d      = 1'b0;
    timeout_d    = 1'b0;
    enter_seed   = 1'b0;

    case (state_q)
      IDLE: begin
        tmo_cnt_d = 16'd0;
        if (guid_req) begin
          if (seed_expired) begin
            enter_seed = 1'b1;
          end else begin
            state_d = WAIT;
            half_d  = 1'b0;
          end
        end
      end

      SEED: begin
        tmo_cnt_d = 16'd0;
        state_d   = WAIT;
      end

      // A valid FIFO word always wins over a pending reseed so the FIFO drains first.
      WAIT: begin
        if (drng_valid) begin
          tmo_cnt_d = 16'd0;
          if (!half_q) begin
            guid_d[127:0] = drng_256_out;
            half_d        = 1'b1;
          end else begin
            guid_d[255:128] = drng_256_out;
            state_d         = PRESENT;
          end
        end else if (seed_expired) begin
          tmo_cnt_d  = 16'd0;
          enter_seed = 1'b1;
        end else begin
          timeout_d = (tmo_cnt_q == TMO_ARM);
          tmo_cnt_d = (tmo_cnt_q == TMO_LAST) ? 16'd0 : tmo_cnt_q + 16'd1;
        end
      end

      PRESENT: begin
        tmo_cnt_d = 16'd0;
        if (guid_ack) begin
          state_d = IDLE;
          half_d  = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        half_d    = 1'b0;
        tmo_cnt_d = 16'd0;
      end
    endcase

    if (enter_seed) begin
      state_d      = SEED;
      start_d      = 1'b1;
      seed_d       = cfg_seed;
      seed_life_d  = cfg_seed_life;
      reseed_cnt_d = (reseed_cnt_q == 16'hFFFF) ? reseed_cnt_q : reseed_cnt_q + 16'd1;
    end

    guid_valid_d = (state_d == PRESENT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      half_q       <= 1'b0;
      tmo_cnt_q    <= 16'd0;
      guid_q       <= '0;
      seed_q       <= '0;
      seed_life_q  <= '0;
      reseed_cnt_q <= 16'd0;
      start_q      <= 1'b0;
      guid_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      half_q       <= half_d;
      tmo_cnt_q    <= tmo_cnt_d;
      guid_q       <= guid_d;
      seed_q       <= seed_d;
      seed_life_q  <= seed_life_d;
      reseed_cnt_q <= reseed_cnt_d;
      start_q      <= start_d;
      guid_valid_q <= guid_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  // Pop is gated by reset so a reset cycle never consumes a FIFO word.
  assign drng_ack       = !rst && (state_q == WAIT) && drng_valid;
  assign guid_valid     = guid_valid_q;
  assign guid           = guid_q;
  assign drng_start     = start_q;
  assign drng_seed      = seed_q;
  assign drng_seed_life = seed_life_q;
  assign guid_timeout   = timeout_q;
  assign reseed_count   = reseed_cnt_q;

endmodule
